// File: rtl/line_scan_ctrl_pkg.sv
// Shared types and defaults for the line scan sequencer and its pixel alignment stage.
package line_scan_ctrl_pkg;

  localparam int PIX_W_DEF   = 12;
  localparam int CNT_W_DEF   = 14;
  localparam int ADC_LAT_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SI     = 3'd1,
    ST_SKIP   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_TAIL   = 3'd4
  } scan_state_e;

  typedef struct packed {
    logic valid;
    logic sol;
    logic eol;
  } sideband_t;

endpackage

// File: rtl/line_scan_align.sv
// Delays pixel framing by ADC_LAT cycles so it lines up with the ADC sample,
// then registers sample and framing together as the output pixel.
module line_scan_align
  import line_scan_ctrl_pkg::*;
#(
  parameter int PIX_W   = PIX_W_DEF,
  parameter int ADC_LAT = ADC_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  sideband_t        push_i,
  input  logic [PIX_W-1:0] din_i,
  output sideband_t        out_o,
  output logic [PIX_W-1:0] data_o,
  output logic             pending_o
);

  sideband_t [ADC_LAT-1:0] dly_q, dly_d;
  sideband_t               out_q, out_d;
  logic [PIX_W-1:0]        data_q, data_d;

  // Shift the framing delay line and capture the sample that matches its head.
  always_comb begin
    dly_d    = dly_q;
    dly_d[0] = push_i;
    for (int i = 1; i < ADC_LAT; i++) begin
      dly_d[i] = dly_q[i-1];
    end
    out_d = dly_q[ADC_LAT-1];
    if (dly_q[ADC_LAT-1].valid) begin
      data_d = din_i;
    end else begin
      data_d = data_q;
    end
  end

  // Any framing still in flight keeps the block busy.
  always_comb begin
    pending_o = 1'b0;
    for (int i = 0; i < ADC_LAT; i++) begin
      pending_o = pending_o | dly_q[i].valid;
    end
  end

  // Delay line and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dly_q  <= '0;
      out_q  <= '0;
      data_q <= '0;
    end else begin
      dly_q  <= dly_d;
      out_q  <= out_d;
      data_q <= data_d;
    end
  end

  assign out_o  = out_q;
  assign data_o = data_q;

endmodule

// File: rtl/line_scan_ctrl.sv
// Line acquisition sequencer: issues SENSOR_SI, walks skip/active/tail pixel
// periods and emits a latency-aligned, SOL/EOL framed pixel stream.
module line_scan_ctrl
  import line_scan_ctrl_pkg::*;
#(
  parameter int PIX_W   = PIX_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int ADC_LAT = ADC_LAT_DEF
) (
  input  logic             ADC_CLK,
  input  logic             ADC_RSTN,
  input  logic             ENABLE,
  input  logic             START,
  input  logic [CNT_W-1:0] CFG_SKIP,
  input  logic [CNT_W-1:0] CFG_ACTIVE,
  input  logic [CNT_W-1:0] CFG_PERIOD,
  input  logic             CLR_OVR,
  input  logic [PIX_W-1:0] ADC_DIN,
  output logic             SENSOR_SI,
  output logic             BUSY,
  output logic [PIX_W-1:0] PIX_DATA,
  output logic             PIX_VALID,
  output logic             PIX_SOL,
  output logic             PIX_EOL,
  input  logic             PIX_READY,
  output logic             OVERRUN,
  output logic [15:0]      LINE_CNT
);

  localparam logic [CNT_W:0] CNT_ONE = {{CNT_W{1'b0}}, 1'b1};

  scan_state_e      state_q, state_d, state_seq;
  logic [CNT_W:0]   pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0] skip_q, skip_d, active_q, active_d, period_q, period_d;
  logic [15:0]      line_cnt_q, line_cnt_d;
  logic             si_q, si_d;
  logic             ovr_q, ovr_d;

  logic [CNT_W-1:0] cur_skip, cur_active, cur_period;
  logic [CNT_W:0]   win_end, span, eff_m1;
  logic             line_end;
  sideband_t        push_s, out_s;
  logic             pending_s;

  // During SI the shadows are still loading, so decisions use the live config.
  always_comb begin
    if (state_q == ST_SI) begin
      cur_skip   = CFG_SKIP;
      cur_active = CFG_ACTIVE;
      cur_period = CFG_PERIOD;
    end else begin
      cur_skip   = skip_q;
      cur_active = active_q;
      cur_period = period_q;
    end
    win_end = {1'b0, cur_skip} + {1'b0, cur_active};
    span    = win_end + CNT_ONE;
    if ({1'b0, cur_period} > span) begin
      eff_m1 = {1'b0, cur_period} - CNT_ONE;
    end else begin
      eff_m1 = win_end;
    end
    line_end = (pix_cnt_q == eff_m1);
  end

  // Next state, pixel counter, shadow config and line counter.
  always_comb begin
    state_seq  = state_q;
    pix_cnt_d  = pix_cnt_q + CNT_ONE;
    skip_d     = skip_q;
    active_d   = active_q;
    period_d   = period_q;
    line_cnt_d = line_cnt_q;
    case (state_q)
      ST_IDLE: begin
        pix_cnt_d = '0;
        if (ENABLE || START) begin
          state_seq = ST_SI;
        end else begin
          state_seq = ST_IDLE;
        end
      end
      ST_SI: begin
        skip_d     = CFG_SKIP;
        active_d   = CFG_ACTIVE;
        period_d   = CFG_PERIOD;
        line_cnt_d = line_cnt_q + 16'd1;
        if (CFG_ACTIVE == '0) begin
          state_seq = ST_TAIL;
        end else if (CFG_SKIP == '0) begin
          state_seq = ST_ACTIVE;
        end else begin
          state_seq = ST_SKIP;
        end
      end
      ST_SKIP: begin
        if (pix_cnt_q == {1'b0, skip_q}) begin
          state_seq = ST_ACTIVE;
        end else begin
          state_seq = ST_SKIP;
        end
      end
      ST_ACTIVE: begin
        if (pix_cnt_q == win_end) begin
          state_seq = ST_TAIL;
        end else begin
          state_seq = ST_ACTIVE;
        end
      end
      ST_TAIL: begin
        state_seq = ST_TAIL;
      end
      default: begin
        state_seq = ST_IDLE;
      end
    endcase

    // The end-of-line point can fall in SI, ACTIVE or TAIL and overrides them.
    if ((state_q != ST_IDLE) && line_end) begin
      pix_cnt_d = '0;
      if (ENABLE) begin
        state_d = ST_SI;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      state_d = state_seq;
    end
  end

  // Framing for the pixel of this cycle and output-side status.
  always_comb begin
    push_s.valid = (state_q == ST_ACTIVE);
    push_s.sol   = push_s.valid && (pix_cnt_q == ({1'b0, skip_q} + CNT_ONE));
    push_s.eol   = push_s.valid && (pix_cnt_q == win_end);
    si_d         = (state_d == ST_SI);
    if (out_s.valid && !PIX_READY) begin
      ovr_d = 1'b1;
    end else if (CLR_OVR) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // Sequencer registers.
  always_ff @(posedge ADC_CLK) begin
    if (!ADC_RSTN) begin
      state_q    <= ST_IDLE;
      pix_cnt_q  <= '0;
      skip_q     <= '0;
      active_q   <= '0;
      period_q   <= '0;
      line_cnt_q <= 16'd0;
      si_q       <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_cnt_q  <= pix_cnt_d;
      skip_q     <= skip_d;
      active_q   <= active_d;
      period_q   <= period_d;
      line_cnt_q <= line_cnt_d;
      si_q       <= si_d;
      ovr_q      <= ovr_d;
    end
  end

  line_scan_align #(
    .PIX_W   (PIX_W),
    .ADC_LAT (ADC_LAT)
  ) u_align (
    .clk       (ADC_CLK),
    .rst_n     (ADC_RSTN),
    .push_i    (push_s),
    .din_i     (ADC_DIN),
    .out_o     (out_s),
    .data_o    (PIX_DATA),
    .pending_o (pending_s)
  );

  assign SENSOR_SI = si_q;
  assign BUSY      = (state_q != ST_IDLE) || pending_s;
  assign PIX_VALID = out_s.valid;
  assign PIX_SOL   = out_s.sol;
  assign PIX_EOL   = out_s.eol;
  assign OVERRUN   = ovr_q;
  assign LINE_CNT  = line_cnt_q;

endmodule

// File: tb/tb_line_scan_ctrl.sv
// Scoreboard bench for line_scan_ctrl: a line-level reference model predicts
// every pixel and status output, a negedge monitor compares each cycle.
module tb_line_scan_ctrl;

  localparam int PIX_W   = 12;
  localparam int CNT_W   = 14;
  localparam int ADC_LAT = 2;

  logic             clk = 1'b0;
  logic             rstn, enable, start, clr, ready;
  logic [CNT_W-1:0] skip, act, per;
  logic [PIX_W-1:0] din;
  logic             sensor_si, busy, pix_valid, pix_sol, pix_eol, overrun;
  logic [PIX_W-1:0] pix_data;
  logic [15:0]      line_cnt;

  always #5 clk = ~clk;

  int cyc = 0;
  logic [PIX_W-1:0] din_tbl [4096];
  assign din = din_tbl[cyc % 4096];

  typedef struct {
    int               cy;
    logic [PIX_W-1:0] d;
    logic             sol;
    logic             eol;
  } pix_t;

  pix_t eq[$];
  int   vq[$];
  int   checks = 0;
  int   errors = 0;

  bit m_line = 1'b0;
  bit m_ovr  = 1'b0;
  bit m_v;
  int m_pos = 0, m_eff = 1, m_lines = 0;
  int m_s, m_a, m_p, m_ac, c;
  pix_t m_px;

  line_scan_ctrl #(.PIX_W(PIX_W), .CNT_W(CNT_W), .ADC_LAT(ADC_LAT)) dut (
    .ADC_CLK    (clk),
    .ADC_RSTN   (rstn),
    .ENABLE     (enable),
    .START      (start),
    .CFG_SKIP   (skip),
    .CFG_ACTIVE (act),
    .CFG_PERIOD (per),
    .CLR_OVR    (clr),
    .ADC_DIN    (din),
    .SENSOR_SI  (sensor_si),
    .BUSY       (busy),
    .PIX_DATA   (pix_data),
    .PIX_VALID  (pix_valid),
    .PIX_SOL    (pix_sol),
    .PIX_EOL    (pix_eol),
    .PIX_READY  (ready),
    .OVERRUN    (overrun),
    .LINE_CNT   (line_cnt)
  );

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  function automatic bit exp_busy();
    bit b = m_line;
    foreach (vq[i]) begin
      if ((vq[i] - ADC_LAT <= cyc) && (cyc <= vq[i] - 1)) b = 1'b1;
    end
    return b;
  endfunction

  // Reference model: one update per clock using the inputs of the ending cycle.
  always @(posedge clk) begin
    c = cyc;
    if (!rstn) begin
      m_line = 1'b0; m_pos = 0; m_lines = 0; m_ovr = 1'b0;
      eq.delete(); vq.delete();
    end else begin
      while (vq.size() > 0 && vq[0] < c) void'(vq.pop_front());
      m_v = (vq.size() > 0) && (vq[0] == c);
      if (m_v && !ready) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
      if (m_line) begin
        if (m_pos == 0) begin
          m_s = int'(skip); m_a = int'(act); m_p = int'(per);
          m_eff = (m_p > 1 + m_s + m_a) ? m_p : 1 + m_s + m_a;
          for (int k = 0; k < m_a; k++) begin
            m_ac     = c + 1 + m_s + k;
            m_px.cy  = m_ac + ADC_LAT + 1;
            m_px.d   = din_tbl[(m_ac + ADC_LAT) % 4096];
            m_px.sol = (k == 0);
            m_px.eol = (k == m_a - 1);
            eq.push_back(m_px);
            vq.push_back(m_px.cy);
          end
          m_lines = (m_lines + 1) % 65536;
        end
        if (m_pos == m_eff - 1) begin
          if (enable) m_pos = 0;
          else m_line = 1'b0;
        end else begin
          m_pos++;
        end
      end else if (enable || start) begin
        m_line = 1'b1;
        m_pos  = 0;
      end
    end
    cyc <= cyc + 1;
  end

  // Monitor: compare every DUT output against the model away from the edge.
  always @(negedge clk) begin
    bit ev;
    while (eq.size() > 0 && eq[0].cy < cyc) void'(eq.pop_front());
    ev = (eq.size() > 0) && (eq[0].cy == cyc);
    chk("pix_valid", int'(pix_valid), int'(ev));
    if (ev) begin
      if (pix_valid) begin
        chk("pix_data", int'(pix_data), int'(eq[0].d));
        chk("pix_sol", int'(pix_sol), int'(eq[0].sol));
        chk("pix_eol", int'(pix_eol), int'(eq[0].eol));
      end
      void'(eq.pop_front());
    end else begin
      chk("sol_idle", int'(pix_sol), 0);
      chk("eol_idle", int'(pix_eol), 0);
    end
    chk("sensor_si", int'(sensor_si), int'(m_line && (m_pos == 0)));
    chk("busy", int'(busy), int'(exp_busy()));
    chk("line_cnt", int'(line_cnt), m_lines);
    chk("overrun", int'(overrun), int'(m_ovr));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic step_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic start_line(input int s, input int a, input int p, output int si);
    skip  = CNT_W'(s);
    act   = CNT_W'(a);
    per   = CNT_W'(p);
    start = 1'b1;
    step(1);
    start = 1'b0;
    si    = cyc;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (!m_line && eq.size() == 0) done = 1'b1;
      else step(1);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL idle_timeout at cycle %0d: got busy expected idle", cyc);
    end
    step(2);
  endtask

  initial begin
    int si;
    foreach (din_tbl[i]) din_tbl[i] = PIX_W'($urandom);
    rstn = 1'b0; enable = 1'b0; start = 1'b0; clr = 1'b0; ready = 1'b1;
    skip = '0; act = '0; per = '0;
    step(3);
    rstn = 1'b1;
    step(2);

    // Basic START line, then three back-to-back ENABLE lines.
    start_line(3, 5, 12, si);
    wait_idle();
    skip = CNT_W'(2); act = CNT_W'(4); per = CNT_W'(10);
    enable = 1'b1;
    step(1);
    si = cyc;
    step_to(si + 25);
    enable = 1'b0;
    wait_idle();

    // Edge configurations.
    start_line(2, 0, 5, si);
    wait_idle();
    start_line(1, 1, 4, si);
    wait_idle();
    start_line(4, 4, 2, si);
    wait_idle();

    // Overrun set, set-wins against clear, then clear alone.
    start_line(1, 6, 10, si);
    step_to(si + 7);
    ready = 1'b0;
    step(1);
    ready = 1'b1;
    step_to(si + 9);
    ready = 1'b0; clr = 1'b1;
    step(1);
    ready = 1'b1; clr = 1'b0;
    wait_idle();
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(2);

    // Reset on the second active pixel, then a clean line.
    start_line(2, 6, 12, si);
    step_to(si + 7);
    rstn = 1'b0;
    step(1);
    chk("rst_pix_data", int'(pix_data), 0);
    rstn = 1'b1;
    step(5);
    start_line(2, 3, 8, si);
    wait_idle();

    // Mid-line config change and ignored START; new SKIP applies next line.
    start_line(3, 4, 12, si);
    step_to(si + 2);
    skip = CNT_W'(0);
    step_to(si + 4);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_idle();
    start_line(0, 4, 12, si);
    wait_idle();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(19) == 0) enable = ~enable;
      start = ($urandom_range(7) == 0);
      if ($urandom_range(15) == 0) begin
        skip = CNT_W'($urandom_range(5));
        act  = CNT_W'($urandom_range(6));
        per  = CNT_W'($urandom_range(15));
      end
      ready = ($urandom_range(7) != 0);
      clr   = ($urandom_range(15) == 0);
      rstn  = ($urandom_range(399) != 0);
      step(1);
    end
    rstn = 1'b1; enable = 1'b0; start = 1'b0; clr = 1'b0; ready = 1'b1;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
